// File: rtl/placement_readout_pkg.sv
// Shared encodings for the placement reader/checker: record status codes,
// the EMPTY/unplaced marker (shared with the placement engine) and FSM states.
package placement_readout_pkg;

    typedef enum logic [1:0] {
        ST_OK            = 2'd0,
        ST_UNPLACED      = 2'd1,
        ST_OUT_OF_RANGE  = 2'd2,
        ST_GRID_MISMATCH = 2'd3
    } status_t;

    // Marks an unplaced node in pos_X/pos_Y and an empty cell in the grid RAM
    localparam int EMPTY = -1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_POS,
        S_WAIT_POS,
        S_CHECK,
        S_RD_GRID,
        S_WAIT_GRID,
        S_CMP,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/placement_rd_wait.sv
// RAM read-latency timer: load on the read-enable cycle, expire_o flags the
// final wait cycle, after which the RAM output is captured.
module placement_rd_wait #(
    parameter int RD_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CW = 3;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(RD_LAT);
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == CW'(1));

endmodule

// File: rtl/placement_readout.sv
// Scans every node of a finished placement, checks its position against the
// grid RAM and streams one classified record per node on a valid/ready port.
module placement_readout
    import placement_readout_pkg::*;
#(
    parameter int N       = 8,
    parameter int N_NODES = 64,
    parameter int DW      = 32,
    parameter int PAW     = 7,
    parameter int GAW     = 12,
    parameter int RD_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rePX,
    output logic                  rePY,
    output logic [PAW-1:0]        addrPX,
    output logic [PAW-1:0]        addrPY,
    input  logic signed [DW-1:0]  doutPX,
    input  logic signed [DW-1:0]  doutPY,
    output logic                  reGrid,
    output logic [GAW-1:0]        addrGrid,
    input  logic signed [DW-1:0]  doutGrid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAW-1:0]        out_node,
    output logic signed [DW-1:0]  out_x,
    output logic signed [DW-1:0]  out_y,
    output logic [1:0]            out_status,
    output logic [PAW:0]          err_count
);

    localparam logic signed [DW-1:0] EMPTY_W = DW'(EMPTY);
    localparam logic signed [DW-1:0] MAX_C   = DW'(N - 1);

    state_t                state_q;
    logic                  busy_q, done_q, rep_q, reg_q, valid_q;
    logic [PAW-1:0]        node_q;
    logic [GAW-1:0]        gaddr_q;
    logic signed [DW-1:0]  ox_q, oy_q;
    status_t               st_q;
    logic [PAW:0]          err_q;

    logic signed [DW-1:0]  x_q, y_q, grid_q;

    logic wait_load, wait_run, wait_exp;
    logic unplaced_d, out_range_d, grid_hit_d, last_node_d;

    // Address is formed at full data width, then only the low GAW bits are kept
    function automatic logic [GAW-1:0] grid_addr(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
        logic signed [DW-1:0] a;
        a = x * DW'(N) + y;
        return a[GAW-1:0];
    endfunction

    assign wait_load = (state_q == S_RD_POS) || (state_q == S_RD_GRID);
    assign wait_run  = (state_q == S_WAIT_POS) || (state_q == S_WAIT_GRID);

    placement_rd_wait #(
        .RD_LAT (RD_LAT)
    ) u_wait (
        .clk_i    (clk),
        .rst_ni   (reset),
        .load_i   (wait_load),
        .run_i    (wait_run),
        .expire_o (wait_exp)
    );

    // The -1 marker is tested before the signed range check
    assign unplaced_d  = (x_q == EMPTY_W) || (y_q == EMPTY_W);
    assign out_range_d = x_q[DW-1] || y_q[DW-1] || (x_q > MAX_C) || (y_q > MAX_C);
    assign grid_hit_d  = (grid_q == $signed(DW'(node_q)));
    assign last_node_d = (node_q == PAW'(N_NODES - 1));

    // RAM read data capture
    always_ff @(posedge clk) begin
        if ((state_q == S_WAIT_POS) && wait_exp) begin
            x_q <= doutPX;
            y_q <= doutPY;
        end
        if ((state_q == S_WAIT_GRID) && wait_exp) begin
            grid_q <= doutGrid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rep_q   <= 1'b0;
            reg_q   <= 1'b0;
            valid_q <= 1'b0;
            node_q  <= '0;
            gaddr_q <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            st_q    <= ST_OK;
            err_q   <= '0;
        end else begin
            rep_q  <= 1'b0;
            reg_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        node_q  <= '0;
                        err_q   <= '0;
                        rep_q   <= 1'b1;
                        state_q <= S_RD_POS;
                    end
                end
                S_RD_POS:   state_q <= S_WAIT_POS;
                S_WAIT_POS: if (wait_exp) state_q <= S_CHECK;
                S_CHECK: begin
                    if (unplaced_d || out_range_d) begin
                        st_q    <= unplaced_d ? ST_UNPLACED : ST_OUT_OF_RANGE;
                        ox_q    <= x_q;
                        oy_q    <= y_q;
                        valid_q <= 1'b1;
                        state_q <= S_EMIT;
                    end else begin
                        reg_q   <= 1'b1;
                        gaddr_q <= grid_addr(x_q, y_q);
                        state_q <= S_RD_GRID;
                    end
                end
                S_RD_GRID:   state_q <= S_WAIT_GRID;
                S_WAIT_GRID: if (wait_exp) state_q <= S_CMP;
                S_CMP: begin
                    st_q    <= grid_hit_d ? ST_OK : ST_GRID_MISMATCH;
                    ox_q    <= x_q;
                    oy_q    <= y_q;
                    valid_q <= 1'b1;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    // Record and RAM traffic freeze until the sink accepts
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        err_q   <= err_q + (PAW+1)'(st_q != ST_OK);
                        if (last_node_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            node_q  <= node_q + PAW'(1);
                            rep_q   <= 1'b1;
                            state_q <= S_RD_POS;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rePX       = rep_q;
    assign rePY       = rep_q;
    assign addrPX     = node_q;
    assign addrPY     = node_q;
    assign reGrid     = reg_q;
    assign addrGrid   = gaddr_q;
    assign out_valid  = valid_q;
    assign out_node   = node_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign out_status = st_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_placement_readout.sv
// Bench for placement_readout: RAM models with read latency, a rule-level
// record model, a per-cycle compare process and directed scan scenarios.
module tb_placement_readout;

    localparam int N   = 8;
    localparam int NN  = 4;
    localparam int DW  = 32;
    localparam int PAW = 7;
    localparam int GAW = 12;
    localparam int RL  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic busy, done, rePX, rePY, reGrid, out_valid;
    logic [PAW-1:0] addrPX, addrPY, out_node;
    logic [GAW-1:0] addrGrid;
    logic signed [DW-1:0] doutPX, doutPY, doutGrid, out_x, out_y;
    logic [1:0] out_status;
    logic [PAW:0] err_count;

    always #5 clk = ~clk;

    placement_readout #(
        .N(N), .N_NODES(NN), .DW(DW), .PAW(PAW), .GAW(GAW), .RD_LAT(RL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rePX(rePX), .rePY(rePY), .addrPX(addrPX), .addrPY(addrPY),
        .doutPX(doutPX), .doutPY(doutPY), .reGrid(reGrid), .addrGrid(addrGrid),
        .doutGrid(doutGrid), .out_valid(out_valid), .out_ready(out_ready),
        .out_node(out_node), .out_x(out_x), .out_y(out_y),
        .out_status(out_status), .err_count(err_count)
    );

    // RAM contents and read pipelines (RL cycles from sampled enable to data)
    int px[NN], py[NN], grid[64];
    logic signed [DW-1:0] pipx[RL], pipy[RL], pipg[RL];

    always @(posedge clk) begin
        pipx[0] <= rePX ? px[addrPX[1:0]] : pipx[0];
        pipy[0] <= rePY ? py[addrPY[1:0]] : pipy[0];
        pipg[0] <= reGrid ? grid[addrGrid[5:0]] : pipg[0];
        for (int k = 1; k < RL; k++) begin
            pipx[k] <= pipx[k-1];
            pipy[k] <= pipy[k-1];
            pipg[k] <= pipg[k-1];
        end
    end
    assign doutPX   = pipx[RL-1];
    assign doutPY   = pipy[RL-1];
    assign doutGrid = pipg[RL-1];

    int vec = 0;
    int miss = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        vec++;
        if (act !== expv) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Classification straight from the placement rules
    function automatic int exp_status(input int n);
        int x, y;
        x = px[n];
        y = py[n];
        if (x == -1 || y == -1) return 1;
        if (x < 0 || x >= N || y < 0 || y >= N) return 2;
        return (grid[x*N + y] == n) ? 0 : 3;
    endfunction

    function automatic int exp_errs();
        int e = 0;
        for (int n = 0; n < NN; n++) if (exp_status(n) != 0) e++;
        return e;
    endfunction

    task automatic set_pos(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
        px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1;
        px[2] = x2; py[2] = y2; px[3] = x3; py[3] = y3;
        for (int i = 0; i < 64; i++) grid[i] = -1;
        for (int n = 0; n < NN; n++)
            if (px[n] >= 0 && px[n] < N && py[n] >= 0 && py[n] < N) grid[px[n]*N + py[n]] = n;
    endtask

    function automatic bit all_zero();
        return !(busy | done | out_valid | rePX | rePY | reGrid) && addrPX == 0 && addrPY == 0 &&
               addrGrid == 0 && out_node == 0 && out_x == 0 && out_y == 0 &&
               out_status == 0 && err_count == 0;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rec_idx, gr_reads, done_cnt, first_re, done_cyc, mon_n;
    bit first_seen;
    int cap_st0, cap_x0, cap_y0, cap_ga0;
    logic pv_valid = 1'b0, pv_ready = 1'b1, pv_re = 1'b0;
    logic [PAW-1:0] pv_node;
    logic signed [DW-1:0] pv_x, pv_y;
    logic [1:0] pv_st;

    // Compare process: every cycle with meaningful outputs, away from the edge
    always @(negedge clk) begin
        if (reset) begin
            if (rePX) begin
                chk("re_pair", {rePY, addrPY}, {1'b1, addrPX});
                chk("re_pulse", pv_re, 0);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_re = cyc;
                end
            end
            if (reGrid) begin
                mon_n = int'(addrPX[1:0]);
                gr_reads++;
                chk("grid_needed", (exp_status(mon_n) == 0 || exp_status(mon_n) == 3), 1);
                chk("grid_addr", addrGrid, px[mon_n]*N + py[mon_n]);
                if (mon_n == 0) cap_ga0 = int'(addrGrid);
            end
            if (out_valid && !out_ready)
                chk("stall_no_re", rePX | rePY | reGrid, 0);
            if (out_valid && pv_valid && !pv_ready)
                chk("stall_hold", (out_node == pv_node && out_x == pv_x &&
                                   out_y == pv_y && out_status == pv_st), 1);
            if (out_valid && out_ready) begin
                if (rec_idx < NN) begin
                    mon_n = rec_idx;
                    chk("rec_node", out_node, mon_n);
                    chk("rec_x", $signed(out_x), px[mon_n]);
                    chk("rec_y", $signed(out_y), py[mon_n]);
                    chk("rec_status", out_status, exp_status(mon_n));
                    if (mon_n == 0) begin
                        cap_st0 = int'(out_status);
                        cap_x0  = int'(out_x);
                        cap_y0  = int'(out_y);
                    end
                end else begin
                    chk("rec_extra", rec_idx, NN - 1);
                end
                rec_idx++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_err_count", err_count, exp_errs());
            end
        end
        pv_valid = out_valid;
        pv_ready = out_ready;
        pv_re    = rePX;
        pv_node  = out_node;
        pv_x     = out_x;
        pv_y     = out_y;
        pv_st    = out_status;
    end

    task automatic run_scan(input string tag, input int exp_err, input int exp_gr,
                            input int exp_lat, input bit dbl_start, input bit stall);
        bit seen = 1'b0;
        rec_idx = 0; gr_reads = 0; done_cnt = 0;
        first_seen = 1'b0; first_re = 0; done_cyc = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        if (dbl_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (stall) begin
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (rePX && addrPX == 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk({tag, "_node1_reached"}, seen, 1);
            @(posedge clk); #1 out_ready = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk({tag, "_stall_valid"}, seen, 1);
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
            seen = 1'b0;
        end
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_records"}, rec_idx, NN);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_grid_reads"}, gr_reads, exp_gr);
        chk({tag, "_idle_busy"}, busy, 0);
        if (exp_lat > 0) chk({tag, "_latency"}, done_cyc - first_re, exp_lat);
    endtask

    initial begin
        bit seen;
        set_pos(0, 0, 1, 2, 7, 7, 3, 4);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", all_zero(), 1);
        reset = 1'b1;

        // All nodes placed and consistent; a second start mid-scan is ignored
        chk("model_s1_n1", exp_status(1), 0);
        run_scan("s1", 0, 4, 36, 1'b1, 1'b0);

        set_pos(0, 0, 1, 2, -1, -1, 3, 4);
        chk("model_s2_n2", exp_status(2), 1);
        run_scan("s2", 1, 3, 32, 1'b0, 1'b0);

        set_pos(0, 0, 8, 0, 7, 7, 2, -3);
        chk("model_s3_n1", exp_status(1), 2);
        chk("model_s3_n3", exp_status(3), 2);
        run_scan("s3", 2, 2, 28, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("s3_err_hold", err_count, 2);

        set_pos(1, 1, 1, 2, 7, 7, 3, 4);
        grid[9] = 3;
        chk("model_s4_n0", exp_status(0), 3);
        run_scan("s4", 1, 4, 36, 1'b0, 1'b0);
        chk("s4_node0_status", cap_st0, 3);
        chk("s4_node0_x", cap_x0, 1);
        chk("s4_node0_y", cap_y0, 1);
        chk("s4_node0_addr", cap_ga0, 9);

        set_pos(0, 0, 1, 2, 7, 7, 3, 4);
        run_scan("s5", 0, 4, 0, 1'b0, 1'b1);

        // Reset while node2 waits on its grid read
        rec_idx = 0; done_cnt = 0; gr_reads = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (reGrid && addrPX == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("s6_reach_node2_grid", seen, 1);
        @(posedge clk); #1 reset = 1'b0;
        #1 chk("s6_async_clear", all_zero(), 1);
        repeat (3) @(negedge clk);
        chk("s6_no_done", done_cnt, 0);
        @(posedge clk); #1 reset = 1'b1;
        run_scan("s6r", 0, 4, 36, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
